// File: rtl/segled_pkg.sv
// Shared constants and types for the SWORD serial 7-segment link receiver.
package segled_pkg;

  localparam int SEG_NBITS = 64;
  localparam int SEG_BYTES = SEG_NBITS / 8;

  // Active-low {g,f,e,d,c,b,a} patterns; index is the hex value shown.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {IDLE, SHIFT} seg_state_t;

endpackage

// File: rtl/segled_rx_seg7_decode.sv
// Combinational decode of one active-low segment byte {dp,g,f,e,d,c,b,a}.
module seg7_decode
  import segled_pkg::*;
(
  input  logic [7:0] seg_byte,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       ok
);

  assign dp = ~seg_byte[7];

  // Table entries are unique, so at most one index matches.
  always_comb begin
    nibble = '0;
    ok     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_byte[6:0] == SEG_TABLE[i]) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segled_rx.sv
// SWORD SEGLED serial receiver: oversampled deserializer plus digit decode.
// Optional frame counter enabled by defining SEGLED_RX_FRAMECNT_EN.
//
// state | meaning
// IDLE  | no bits of a frame received yet (bit_count = 0)
// SHIFT | partial frame in progress, guarded by the idle timeout
module segled_rx
  import segled_pkg::*;
#(
  parameter int NBITS       = 8 * SEG_BYTES,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SEGLED_CLK,
  input  logic                     SEGLED_DO,
  input  logic                     SEGLED_PEN,
  input  logic                     SEGLED_CLR,
  output logic [NBITS-1:0]         frame,
  output logic                     frame_valid,
  output logic [4*NBITS/8-1:0]     digits,
  output logic [NBITS/8-1:0]       dp,
  output logic [NBITS/8-1:0]       digit_ok,
  output logic                     display_on,
  output logic                     err_partial,
  output logic [$clog2(NBITS):0]   bit_count,
  output logic [15:0]              frame_cnt
);

  localparam int CW = $clog2(NBITS) + 1;
  localparam int NB = NBITS / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sck_s, do_s, pen_s, clr_s;
  logic                   sck_prev;
  logic                   sck_rise, do_bit, clr_act;

  seg_state_t       state_q, state_d;
  logic [NBITS-2:0] shift_q, shift_d;
  logic [NBITS-1:0] shift_next;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             complete, drop;

  logic [4*NB-1:0]  dec_digits;
  logic [NB-1:0]    dec_dp, dec_ok;

  // PEN and CLR are synchronized already inverted so reset (all zero) means
  // display off and no clear pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s    <= '0;
      do_s     <= '0;
      pen_s    <= '0;
      clr_s    <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_s    <= {sck_s[SYNC_STAGES-2:0], SEGLED_CLK};
      do_s     <= {do_s[SYNC_STAGES-2:0], SEGLED_DO};
      pen_s    <= {pen_s[SYNC_STAGES-2:0], ~SEGLED_PEN};
      clr_s    <= {clr_s[SYNC_STAGES-2:0], ~SEGLED_CLR};
      sck_prev <= sck_s[SYNC_STAGES-1];
    end
  end

  assign sck_rise   = sck_s[SYNC_STAGES-1] & ~sck_prev;
  assign do_bit     = do_s[SYNC_STAGES-1];
  assign clr_act    = clr_s[SYNC_STAGES-1];
  assign display_on = pen_s[SYNC_STAGES-1];
  assign shift_next = {shift_q, do_bit};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    complete = 1'b0;
    drop     = 1'b0;
    if (sck_rise)          tmr_d = TMR_LOAD;
    else if (tmr_q != '0)  tmr_d = tmr_q - TW'(1);
    else                   tmr_d = tmr_q;

    if (clr_act) begin
      state_d = IDLE;
      shift_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sck_rise) begin
            shift_d = shift_next[NBITS-2:0];
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shift_d = shift_next[NBITS-2:0];
            if (count_q == LAST) begin
              complete = 1'b1;
              count_d  = '0;
              state_d  = IDLE;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else if (tmr_q == '0) begin
            drop    = 1'b1;
            shift_d = '0;
            count_d = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_dec
    seg7_decode u_dec (
      .seg_byte (shift_next[8*k +: 8]),
      .nibble   (dec_digits[4*k +: 4]),
      .dp       (dec_dp[k]),
      .ok       (dec_ok[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      tmr_q       <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      digits      <= '0;
      dp          <= '0;
      digit_ok    <= '0;
      err_partial <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      tmr_q       <= tmr_d;
      frame_valid <= complete;
      err_partial <= drop;
      if (complete) begin
        frame    <= shift_next;
        digits   <= dec_digits;
        dp       <= dec_dp;
        digit_ok <= dec_ok;
      end
    end
  end

  assign bit_count = count_q;

`ifdef SEGLED_RX_FRAMECNT_EN
  logic [15:0] fcnt_q;
  always_ff @(posedge clk) begin
    if (reset)         fcnt_q <= '0;
    else if (complete) fcnt_q <= fcnt_q + 16'd1;
  end
  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_segled_rx.sv
// Directed bench for segled_rx: table-driven frames plus timeout/clear/reset sequences.
module tb_segled_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR;
  logic [63:0] frame;
  logic        frame_valid;
  logic [31:0] digits;
  logic [7:0]  dp, digit_ok;
  logic        display_on, err_partial;
  logic [6:0]  bit_count;
  logic [15:0] frame_cnt;

  segled_rx dut (
    .clk         (clk),
    .reset       (reset),
    .SEGLED_CLK  (SEGLED_CLK),
    .SEGLED_DO   (SEGLED_DO),
    .SEGLED_PEN  (SEGLED_PEN),
    .SEGLED_CLR  (SEGLED_CLR),
    .frame       (frame),
    .frame_valid (frame_valid),
    .digits      (digits),
    .dp          (dp),
    .digit_ok    (digit_ok),
    .display_on  (display_on),
    .err_partial (err_partial),
    .bit_count   (bit_count),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int ep_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err_partial) ep_cnt++;
  end

  typedef struct {
    logic [63:0] word;
    logic [31:0] dig;
    logic [7:0]  dpx;
    logic [7:0]  ok;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bit = 4 clk low then 4 clk high on SEGLED_CLK; ends with SEGLED_CLK low.
  task automatic send_bits(input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      SEGLED_DO  = val[63-i];
      SEGLED_CLK = 1'b0;
      repeat (4) @(negedge clk);
      SEGLED_CLK = 1'b1;
      repeat (4) @(negedge clk);
    end
    SEGLED_CLK = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input vec_t v);
    chk({nm, " frame"}, frame, v.word);
    chk({nm, " digits"}, {32'h0, digits}, {32'h0, v.dig});
    chk({nm, " dp"}, {56'h0, dp}, {56'h0, v.dpx});
    chk({nm, " digit_ok"}, {56'h0, digit_ok}, {56'h0, v.ok});
    chk({nm, " bit_count"}, {57'h0, bit_count}, 64'h0);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " frame"}, frame, 64'h0);
    chk({nm, " misc"}, {frame_valid, err_partial, display_on, bit_count, frame_cnt},
        64'h0);
    chk({nm, " decode"}, {digits, dp, digit_ok}, 64'h0);
  endtask

  initial begin
    int fv0, ep0;
    logic [63:0] prev_frame;
    logic [2:0]  lat;

    vecs[0] = '{64'hF9A4B0999282F880, 32'h12345678, 8'h00, 8'hFF};
    vecs[1] = '{64'h40F9A4B0999282F8, 32'h01234567, 8'h80, 8'hFF};
    vecs[2] = '{64'hF9A4B0999282F8FF, 32'h12345670, 8'h00, 8'hFE};
    vecs[3] = '{64'h8883C6A1868E4079, 32'hABCDEF01, 8'h03, 8'hFF};
    vecs[4] = '{64'h00107F00FFFF1200, 32'h89080058, 8'hF3, 8'hD3};

    reset = 1'b1;
    SEGLED_CLK = 1'b0; SEGLED_DO = 1'b0; SEGLED_PEN = 1'b1; SEGLED_CLR = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // display_on follows ~PEN two cycles later
    SEGLED_PEN = 1'b0;
    @(negedge clk);
    chk("pen lag1", {63'h0, display_on}, 64'h0);
    @(negedge clk);
    chk("pen lag2", {63'h0, display_on}, 64'h1);

    // Table-driven frames; last bit sent by hand to check pin-to-valid latency.
    for (int v = 0; v < 5; v++) begin
      fv0 = fv_cnt;
      send_bits(vecs[v].word, 63);
      chk($sformatf("vec%0d count63", v), {57'h0, bit_count}, 64'd63);
      SEGLED_DO = vecs[v].word[0];
      SEGLED_CLK = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        lat[c] = frame_valid;
      end
      chk($sformatf("vec%0d latency", v), {61'h0, lat}, 64'b100);
      repeat (4) @(negedge clk);
      SEGLED_CLK = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d valid count", v), 64'(fv_cnt - fv0), 64'd1);
      check_frame($sformatf("vec%0d", v), vecs[v]);
    end

    // Timeout: 40 bits then silence.
    prev_frame = frame;
    fv0 = fv_cnt; ep0 = ep_cnt;
    send_bits(64'hDEADBEEF01234567, 40);
    chk("to count40", {57'h0, bit_count}, 64'd40);
    repeat (1000) @(negedge clk);
    chk("to not early", 64'(ep_cnt - ep0), 64'd0);
    for (int c = 0; c < 200 && ep_cnt == ep0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("to err pulse", 64'(ep_cnt - ep0), 64'd1);
    chk("to bit_count", {57'h0, bit_count}, 64'h0);
    chk("to frame kept", frame, prev_frame);
    chk("to no valid", 64'(fv_cnt - fv0), 64'd0);
    fv0 = fv_cnt;
    send_bits(vecs[1].word, 64);
    chk("to next valid", 64'(fv_cnt - fv0), 64'd1);
    check_frame("to next", vecs[1]);

    // CLR after 20 bits, then one full frame.
    fv0 = fv_cnt; ep0 = ep_cnt;
    send_bits(64'h0123456789ABCDEF, 20);
    SEGLED_CLR = 1'b0;
    repeat (4) @(negedge clk);
    SEGLED_CLR = 1'b1;
    repeat (4) @(negedge clk);
    chk("clr bit_count", {57'h0, bit_count}, 64'h0);
    send_bits(vecs[0].word, 64);
    chk("clr valid count", 64'(fv_cnt - fv0), 64'd1);
    chk("clr no err", 64'(ep_cnt - ep0), 64'd0);
    check_frame("clr next", vecs[0]);

    // CLR coinciding with the completing edge drops the frame.
    fv0 = fv_cnt;
    send_bits(vecs[3].word, 63);
    SEGLED_DO = vecs[3].word[0];
    SEGLED_CLR = 1'b0;
    SEGLED_CLK = 1'b1;
    repeat (4) @(negedge clk);
    SEGLED_CLR = 1'b1;
    SEGLED_CLK = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr64 no valid", 64'(fv_cnt - fv0), 64'd0);
    chk("clr64 bit_count", {57'h0, bit_count}, 64'h0);
    chk("clr64 frame kept", frame, vecs[0].word);

    // Fresh reset, two back-to-back frames, then reset mid-third.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fv0 = fv_cnt;
    send_bits(vecs[2].word, 64);
    send_bits(vecs[3].word, 64);
    chk("b2b valid count", 64'(fv_cnt - fv0), 64'd2);
    check_frame("b2b", vecs[3]);
`ifdef SEGLED_RX_FRAMECNT_EN
    chk("b2b frame_cnt", {48'h0, frame_cnt}, 64'd2);
`else
    chk("b2b frame_cnt", {48'h0, frame_cnt}, 64'd0);
`endif
    send_bits(vecs[4].word, 30);
    chk("mid count30", {57'h0, bit_count}, 64'd30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
